// File: rtl/int_generator.sv
// int_generator: programmable external-interrupt source for the pipelined MIPS
// system. It raises a level request periodically or on a PC match. The
// handler's acknowledge store clears the request. It also keeps request and
// acknowledge statistics.
module int_generator #(
    parameter logic [31:0] ACK_ADDR = 32'h0000_7F20,
    parameter int          PERIOD   = 200,
    parameter int          MAX_IRQ  = 0,
    parameter int          TRIG_EN  = 0,
    parameter logic [31:0] TRIG_PC  = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] macroscopic_pc,
    input  logic [31:0] m_int_addr,
    input  logic [3:0]  m_int_byteen,
    output logic        interrupt,
    output logic [15:0] irq_count,
    output logic [15:0] ack_count,
    output logic        spurious_ack,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_COUNT   = 2'd0,
        ST_PENDING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [15:0] LP_RELOAD  = 16'(PERIOD - 1);
    localparam logic [15:0] LP_MAX_IRQ = 16'(MAX_IRQ);
    localparam logic        LP_LIMITED = (MAX_IRQ != 0);
    localparam logic        LP_TRIG_EN = (TRIG_EN != 0);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_cnt;
    logic [31:0] r_pc_prev;
    logic [15:0] r_irq_count;
    logic [15:0] r_ack_count;
    logic        r_spurious;

    logic        w_ack;
    logic        w_pc_hit;
    logic        w_fire;
    logic        w_ack_taken;
    logic [15:0] w_ack_count_inc;
    logic        w_unused_addr_bits;

    // The acknowledge register is word-addressed, so the byte offset is ignored.
    assign w_unused_addr_bits = ^m_int_addr[1:0];
    assign w_ack = (m_int_addr[31:2] == ACK_ADDR[31:2]) && (m_int_byteen != 4'd0);

    // Fire only on the first cycle the PC reaches the trigger address. Without
    // this, a PC that stalls on the trigger would fire again after every ack.
    assign w_pc_hit = LP_TRIG_EN && (macroscopic_pc == TRIG_PC) && (r_pc_prev != TRIG_PC);

    assign w_fire          = (r_state == ST_COUNT) && ((r_cnt == 16'd0) || w_pc_hit);
    assign w_ack_taken     = (r_state == ST_PENDING) && w_ack;
    assign w_ack_count_inc = r_ack_count + 16'd1;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of the order in which processes evaluate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_COUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection: count -> pending on a request; pending -> count or done on ack.
    // NOTE: the default assignment at the top keeps this combinational block
    // latch-free on paths that do not assign the signal.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_COUNT: begin
                if (w_fire) begin
                    w_state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (w_ack) begin
                    if (LP_LIMITED && (w_ack_count_inc == LP_MAX_IRQ)) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_COUNT;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_COUNT;
            end
        endcase
    end

    // Outputs decode the state flop directly, so no input reaches them combinationally.
    always_comb begin
        interrupt    = (r_state == ST_PENDING);
        done         = (r_state == ST_DONE);
        irq_count    = r_irq_count;
        ack_count    = r_ack_count;
        spurious_ack = r_spurious;
    end

    // Datapath: countdown, previous PC, request/ack statistics and the sticky spurious flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= LP_RELOAD;
            r_pc_prev   <= 32'd0;
            r_irq_count <= 16'd0;
            r_ack_count <= 16'd0;
            r_spurious  <= 1'b0;
        end else begin
            r_pc_prev <= macroscopic_pc;

            if ((r_state == ST_COUNT) && !w_fire) begin
                r_cnt <= r_cnt - 16'd1;
            end

            if (w_fire) begin
                r_irq_count <= r_irq_count + 16'd1;
            end

            if (w_ack_taken) begin
                r_cnt       <= LP_RELOAD;
                r_ack_count <= w_ack_count_inc;
            end

            if (w_ack && (r_state != ST_PENDING)) begin
                r_spurious <= 1'b1;
            end
        end
    end

endmodule
